// File: rtl/hni_qos_req_sched.sv
// hni_qos_req_sched: two-class (high/low QoS) request scheduler for the HNI
// RN-F MSHR entries. Each class uses round-robin. High beats low. The chosen
// entry is registered and held under a valid/ready handshake until it is
// accepted.
// Optional feature macro: HNI_QOS_STARVE_PROMOTE_EN. When it is defined, a
// starvation counter promotes the low class after STARVE_THRESH consecutive
// high grants that were made while low requests were pending.
module hni_qos_req_sched #(
  parameter int ENTRIES_NUM   = 16,
  parameter int ENTRY_IDX_W   = 4,
  parameter int STARVE_THRESH = 4,
  parameter int STARVE_CNT_W  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ENTRIES_NUM-1:0] req_vec,
  input  logic [ENTRIES_NUM-1:0] req_hi_vec,
  input  logic                   sched_ready,
  output logic                   sched_valid,
  output logic [ENTRIES_NUM-1:0] sched_sel_vec,
  output logic [ENTRY_IDX_W-1:0] sched_sel_idx,
  output logic                   sched_sel_hi,
  output logic                   sched_promoted
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                 state;
  logic [ENTRIES_NUM-1:0] ptr_hi, ptr_lo, ptr_hi_nxt, ptr_lo_nxt;
  logic [ENTRIES_NUM-1:0] elig, hi_req, lo_req, class_req, class_ptr, masked_req, pick_vec;
  logic                   accept, withdraw, promote, pick_hi, pick_valid, load, clear;

`ifdef HNI_QOS_STARVE_PROMOTE_EN
  localparam logic [STARVE_CNT_W-1:0] THRESH_CNT = STARVE_CNT_W'(STARVE_THRESH);
  logic [STARVE_CNT_W-1:0] starve_cnt, cnt_nxt;
  logic [ENTRIES_NUM-1:0]  lo_all;
`else
  // Keeps the starvation parameters referenced while promotion is compiled out.
  logic unused_starve_cfg;
  assign unused_starve_cfg = (STARVE_THRESH > STARVE_CNT_W);
`endif

  // Lowest set bit of v, returned as a one-hot vector.
  function automatic logic [ENTRIES_NUM-1:0] lowest_bit(input logic [ENTRIES_NUM-1:0] v);
    logic [ENTRIES_NUM-1:0] r;
    logic                   found;
    r     = '0;
    found = 1'b0;
    for (int i = 0; i < ENTRIES_NUM; i++) begin
      if (v[i] && !found) begin
        r[i]  = 1'b1;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // Thermometer mask that keeps only the entries above k.
  function automatic logic [ENTRIES_NUM-1:0] above_mask(input logic [ENTRY_IDX_W-1:0] k);
    logic [ENTRIES_NUM-1:0] m;
    m = '0;
    for (int i = 0; i < ENTRIES_NUM; i++) m[i] = (i > int'(k));
    return m;
  endfunction

  // Binary encode of a one-hot vector.
  function automatic logic [ENTRY_IDX_W-1:0] encode(input logic [ENTRIES_NUM-1:0] v);
    logic [ENTRY_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < ENTRIES_NUM; i++) begin
      if (v[i]) idx = ENTRY_IDX_W'(i);
    end
    return idx;
  endfunction

  // Accept and withdraw decode, mask and counter updates, and the fresh pick.
  always_comb begin
    // NOTE: each variable gets a default first, so no path leaves it unassigned and no latch is inferred.
    accept     = (state == HOLD) && sched_ready;
    withdraw   = (state == HOLD) && !sched_ready && ((req_vec & sched_sel_vec) == '0);
    ptr_hi_nxt = ptr_hi;
    ptr_lo_nxt = ptr_lo;
    if (accept) begin
      if (sched_sel_hi) ptr_hi_nxt = above_mask(sched_sel_idx);
      else              ptr_lo_nxt = above_mask(sched_sel_idx);
    end
    // The accepted entry is excluded from the pick made in the same cycle.
    elig   = accept ? (req_vec & ~sched_sel_vec) : req_vec;
    hi_req = elig & req_hi_vec;
    lo_req = elig & ~req_hi_vec;
`ifdef HNI_QOS_STARVE_PROMOTE_EN
    lo_all  = req_vec & ~req_hi_vec;
    cnt_nxt = starve_cnt;
    if (lo_all == '0) begin
      cnt_nxt = '0;
    end else if (accept) begin
      if (!sched_sel_hi)                 cnt_nxt = '0;
      else if (starve_cnt != THRESH_CNT) cnt_nxt = starve_cnt + STARVE_CNT_W'(1);
    end
    promote = (cnt_nxt == THRESH_CNT) && (lo_req != '0);
`else
    promote = 1'b0;
`endif
    pick_hi    = !promote && (hi_req != '0);
    class_req  = pick_hi ? hi_req : lo_req;
    class_ptr  = pick_hi ? ptr_hi_nxt : ptr_lo_nxt;
    masked_req = class_req & class_ptr;
    pick_vec   = (masked_req != '0) ? lowest_bit(masked_req) : lowest_bit(class_req);
    pick_valid = (elig != '0);
    load       = ((state == IDLE) || accept) && pick_valid;
    clear      = (((state == IDLE) || accept) && !pick_valid) || withdraw;
  end

  // Handshake FSM with the registered selection and the round-robin masks.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    if (rst) begin
      state         <= IDLE;
      ptr_hi        <= '0;
      ptr_lo        <= '0;
      sched_valid   <= 1'b0;
      sched_sel_vec <= '0;
      sched_sel_idx <= '0;
      sched_sel_hi  <= 1'b0;
    end else begin
      ptr_hi <= ptr_hi_nxt;
      ptr_lo <= ptr_lo_nxt;
      if (load) begin
        state         <= HOLD;
        sched_valid   <= 1'b1;
        sched_sel_vec <= pick_vec;
        sched_sel_idx <= encode(pick_vec);
        sched_sel_hi  <= pick_hi;
      end else if (clear) begin
        state         <= IDLE;
        sched_valid   <= 1'b0;
        sched_sel_vec <= '0;
        sched_sel_idx <= '0;
        sched_sel_hi  <= 1'b0;
      end
    end
  end

`ifdef HNI_QOS_STARVE_PROMOTE_EN
  // Starvation counter and the promoted flag that travels with the selection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt     <= '0;
      sched_promoted <= 1'b0;
    end else begin
      starve_cnt <= cnt_nxt;
      if (load)       sched_promoted <= promote;
      else if (clear) sched_promoted <= 1'b0;
    end
  end
`else
  assign sched_promoted = 1'b0;
`endif

endmodule
